// File: rtl/core_ex_muldiv.sv
// core_ex_muldiv: iterative radix-2 multiply (shift-add) / unsigned divide (restoring) unit
module core_ex_muldiv #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] operand_a,
  input  logic [DW-1:0] operand_b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          div_by_zero
);
  localparam int CW = $clog2(DW + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]      r_state;
  logic [1:0]      r_op;
  logic [DW-1:0]   r_b;
  logic [2*DW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_result;
  logic            r_dbz;
  logic [DW:0]     w_sum;
  logic [DW:0]     w_pr;
  logic [DW:0]     w_trial;
  logic [2*DW-1:0] w_mul;
  logic [2*DW-1:0] w_div;
  logic [2*DW-1:0] w_next;
  logic [DW-1:0]   w_res;
  // One iteration of the shared datapath: r_acc is {hi, lo} for multiply and {rem, quot} for divide
  always_comb begin
    w_sum   = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul   = {w_sum, r_acc[DW-1:1]};
    w_pr    = r_acc[2*DW-1:DW-1];
    w_trial = w_pr - {1'b0, r_b};
    w_div   = {w_trial[DW] ? w_pr[DW-1:0] : w_trial[DW-1:0], r_acc[DW-2:0], ~w_trial[DW]};
    w_next  = r_op[1] ? w_div : w_mul;
    w_res   = r_op[0] ? w_next[2*DW-1:DW] : w_next[DW-1:0];
  end
  // Control FSM, operand latch, iteration and result capture on entry to DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_state <= S_RUN;
        r_op    <= op;
        r_b     <= operand_b;
        r_acc   <= {{DW{1'b0}}, operand_a};
        r_cnt   <= CW'(DW);
      end
    end else if (r_state == S_RUN) begin
      r_acc <= w_next;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_state  <= S_DONE;
        r_result <= w_res;
        r_dbz    <= r_op[1] & (r_b == '0);
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
  assign busy        = r_state != S_IDLE;
  assign done        = r_state == S_DONE;
  assign result      = r_result;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_core_ex_muldiv.sv
// tb_core_ex_muldiv: randomized scoreboard bench for core_ex_muldiv against an arithmetic reference model
module tb_core_ex_muldiv;
  localparam int DW = 32;
  localparam longint LAT = 33;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    op = '0;
  logic [DW-1:0] operand_a = '0;
  logic [DW-1:0] operand_b = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          div_by_zero;
  typedef struct {
    logic [DW-1:0] res;
    logic          dbz;
    longint        t;
  } exp_t;
  exp_t          q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  longint        cyc = 0;
  logic [DW-1:0] last_res = '0;
  logic          busy_chk = 1'b0;

  core_ex_muldiv #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y, input longint t);
    exp_t e;
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    case (o)
      2'd0: e.res = p[DW-1:0];
      2'd1: e.res = p[2*DW-1:DW];
      2'd2: e.res = (y == 0) ? {DW{1'b1}} : x / y;
      default: e.res = (y == 0) ? x : x % y;
    endcase
    e.dbz = o[1] && (y == 0);
    e.t = t;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done, otherwise checks that result is held
  always @(negedge clk) begin
    if (rst) begin
      if (busy_chk) begin
        check("busy_after_done", busy, 0);
        busy_chk = 1'b0;
      end
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with result 0x%0h, expected no done", result);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", result, e.res);
          check("div_by_zero", div_by_zero, e.dbz);
          check("latency", cyc - e.t, LAT);
        end
        busy_chk = 1'b1;
      end else begin
        check("result_hold", result, last_res);
      end
    end
    last_res = result;
  end

  task automatic issue(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("idle_wait_timeout", busy, 0);
    op = o;
    operand_a = x;
    operand_b = y;
    start = 1'b1;
    q.push_back(model(o, x, y, cyc));
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 64'(q.size()), 0);
      q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    o;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    issue(2'd0, 7, 6);                  wait_done();
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    issue(2'd2, 100, 7);                wait_done();
    issue(2'd3, 100, 7);                wait_done();
    issue(2'd2, 32'h8000_0000, 1);      wait_done();
    issue(2'd2, 5, 0);                  wait_done();
    issue(2'd3, 5, 0);                  wait_done();
    @(negedge clk);
    issue(2'd0, 3, 3);
    repeat (4) @(negedge clk);
    start = 1'b1;
    operand_a = 11;
    operand_b = 13;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    q.delete();
    @(negedge clk);
    flush = 1'b0;
    check("busy_after_flush", busy, 0);
    check("result_after_flush", result, 5);
    @(negedge clk);
    issue(2'd0, 9, 9);                  wait_done();
    issue(2'd2, 32'hDEAD_BEEF, 32'h1234);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    check("async_reset_result", result, 0);
    check("async_reset_dbz", div_by_zero, 0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    issue(2'd3, 1000, 33);              wait_done();
    repeat (40) begin
      o = 2'($urandom);
      x = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
      y = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
      issue(o, x, y);
      wait_done();
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
